data_mem_ctrl: RTL

Handshaked data-memory controller for the CoreCpu load/store path, and the parametrised successor to the fixed single-port data memory. It decodes each request into on-chip RAM, MMIO or unmapped space. It handles byte/half/word accesses with byte-lane strobes and sign/zero extension. It runs MMIO transactions over a req/ack handshake with an optional timeout, and returns exactly one response per accepted request.

---
 rtl/data_mem_ctrl.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: load/store controller decoding requests into RAM, MMIO or unmapped space.
// Define DATA_MEM_CTRL_MMIO_TIMEOUT_EN to build the MMIO ack timeout.
module data_mem_ctrl #(
  parameter int          ADDR_W       = 32,
  parameter int          RAM_DEPTH    = 16384,
  parameter int unsigned MMIO_BASE_HI = 32'h0000_FFFF,
  parameter int          MMIO_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mmio_req,
  output logic              mmio_we,
  output logic [ADDR_W-1:0] mmio_addr,
  output logic [31:0]       mmio_wdata,
  output logic [3:0]        mmio_wstrb,
  input  logic              mmio_ack,
  input  logic [31:0]       mmio_rdata
);

  localparam int IW = $clog2(RAM_DEPTH);
  localparam int HW = ADDR_W - 16;
  localparam logic [ADDR_W:0] RAM_BYTES =
    (ADDR_W+1)'(RAM_DEPTH) << 2;

  typedef enum logic [1:0] {
    IDLE,
    RAM_RD,
    MMIO_WAIT
  } state_t;

  state_t state, state_n;

  logic        accept;
  logic        ram_hit;
  logic        mmio_hit;
  logic        bad_align;
  logic        req_err;
  logic        ram_ok;
  logic        mmio_go;
  logic [3:0]  strb;
  logic [31:0] wrep;
  logic [31:0] rd_q;
  logic [1:0]  ld_off;
  logic [1:0]  ld_size;
  logic        ld_uns;
  logic        tmo;
  logic        rv_n;
  logic        re_n;
  logic [31:0] rd_n;
  logic [IW-1:0] widx;

  logic [31:0] mem [RAM_DEPTH];

  function automatic logic [31:0] ext(
    input logic [31:0] w,
    input logic [1:0]  off,
    input logic [1:0]  sz,
    input logic        uns
  );
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> {off, 3'b000});
    h = 16'(w >> {off[1], 4'b0000});
    if (sz == 2'b00)
      ext = {{24{b[7] & ~uns}}, b};
    else if (sz == 2'b01)
      ext = {{16{h[15] & ~uns}}, h};
    else
      ext = w;
  endfunction

  assign req_ready = (state == IDLE);
  assign accept    = req_valid & req_ready;
  assign widx      = req_addr[IW+1:2];

  assign ram_hit  = {1'b0, req_addr} < RAM_BYTES;
  assign mmio_hit = req_addr[ADDR_W-1:16] == HW'(MMIO_BASE_HI);

  always_comb begin
    bad_align = 1'b0;
    strb      = 4'b0000;
    wrep      = req_wdata;
    unique case (1'b1)
      req_size == 2'b00: begin
        strb = 4'b0001 << req_addr[1:0];
        wrep = {4{req_wdata[7:0]}};
      end
      req_size == 2'b01: begin
        strb      = 4'b0011 << {req_addr[1], 1'b0};
        wrep      = {2{req_wdata[15:0]}};
        bad_align = req_addr[0];
      end
      req_size == 2'b10: begin
        strb      = 4'b1111;
        bad_align = |req_addr[1:0];
      end
      default: bad_align = 1'b1;
    endcase
  end

  assign req_err = bad_align | ~(ram_hit | mmio_hit);
  assign ram_ok  = ram_hit & ~req_err;
  assign mmio_go = mmio_hit & ~ram_hit & ~req_err;

  // RAM keeps its contents across reset
  always_ff @(posedge clk) begin
    if (accept && ram_ok) begin
      if (req_we) begin
        for (int i = 0; i < 4; i++)
          if (strb[i])
            mem[widx][8*i +: 8] <= wrep[8*i +: 8];
      end else begin
        rd_q <= mem[widx];
      end
    end
  end

`ifdef DATA_MEM_CTRL_MMIO_TIMEOUT_EN
  localparam int CW = $clog2(MMIO_TIMEOUT + 1);
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      cnt <= '0;
    else if (state != MMIO_WAIT)
      cnt <= '0;
    else if (!mmio_ack)
      cnt <= cnt + 1'b1;
  end

  assign tmo = (cnt == CW'(MMIO_TIMEOUT - 1));
`else
  // MMIO_TIMEOUT is at least 1, so this never fires
  assign tmo = (MMIO_TIMEOUT < 1);
`endif

  always_comb begin
    state_n = state;
    rv_n    = 1'b0;
    re_n    = 1'b0;
    rd_n    = 32'd0;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_err) begin
            rv_n = 1'b1;
            re_n = 1'b1;
          end else if (ram_hit) begin
            if (req_we)
              rv_n = 1'b1;
            else
              state_n = RAM_RD;
          end else begin
            state_n = MMIO_WAIT;
          end
        end
      end
      RAM_RD: begin
        rv_n    = 1'b1;
        rd_n    = ext(rd_q, ld_off, ld_size, ld_uns);
        state_n = IDLE;
      end
      MMIO_WAIT: begin
        if (mmio_ack) begin
          rv_n    = 1'b1;
          rd_n    = mmio_we ? 32'd0 :
                    ext(mmio_rdata, ld_off, ld_size, ld_uns);
          state_n = IDLE;
        end else if (tmo) begin
          rv_n    = 1'b1;
          re_n    = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
      ld_off     <= 2'b00;
      ld_size    <= 2'b00;
      ld_uns     <= 1'b0;
      mmio_req   <= 1'b0;
      mmio_we    <= 1'b0;
      mmio_addr  <= '0;
      mmio_wdata <= 32'd0;
      mmio_wstrb <= 4'b0000;
    end else begin
      resp_valid <= rv_n;
      resp_rdata <= rd_n;
      resp_err   <= re_n;
      if (accept) begin
        ld_off  <= req_addr[1:0];
        ld_size <= req_size;
        ld_uns  <= req_unsigned;
      end
      if (accept && mmio_go) begin
        mmio_req   <= 1'b1;
        mmio_we    <= req_we;
        mmio_addr  <= req_addr;
        mmio_wdata <= wrep;
        mmio_wstrb <= strb;
      end else if (state == MMIO_WAIT && state_n == IDLE) begin
        mmio_req <= 1'b0;
      end
    end
  end

endmodule
